// File: rtl/gps_epoch_scheduler_pkg.sv
// Shared constants and the queued-entry layout for the GPS epoch scheduler.
// A queue entry packs the channel index above the captured timestamp.
package gps_epoch_scheduler_pkg;
   localparam int NUM_CH  = 8;
   localparam int CH_W    = 3;
   localparam int TS_W    = 32;
   localparam int FIFO_AW = 4;
   localparam int ENTRY_W = CH_W + TS_W;

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic [TS_W-1:0] ts;
   } entry_t;
endpackage

// File: rtl/gps_sync_fifo.sv
// Single-clock show-ahead FIFO with a level output.
// Pointers carry one extra bit so that full and empty are both encoded in wr - rd.
module gps_sync_fifo #(
   parameter int DW = 35,
   parameter int AW = 4
) (
   input  logic          mclk,
   input  logic          mclr,
   input  logic          push_i,
   input  logic [DW-1:0] data_i,
   input  logic          pop_i,
   output logic          rd_valid_o,
   output logic [DW-1:0] data_o,
   output logic [AW:0]   level_o,
   output logic          full_o
);
   logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   level_s;
   logic          empty_s, push_s, pop_s;
   logic [DW-1:0] mem_q [2**AW];

   assign level_s = wr_q - rd_q;

   // Flags, qualified push/pop, and next pointers; head reads as zero when empty.
   always_comb begin
      empty_s = (level_s == {(AW+1){1'b0}});
      full_o  = (level_s == {1'b1, {AW{1'b0}}});
      push_s  = push_i & ~full_o;
      pop_s   = pop_i & ~empty_s;
      wr_d    = push_s ? (wr_q + {{AW{1'b0}}, 1'b1}) : wr_q;
      rd_d    = pop_s  ? (rd_q + {{AW{1'b0}}, 1'b1}) : rd_q;
      if (empty_s) begin
         data_o = {DW{1'b0}};
      end else begin
         data_o = mem_q[rd_q[AW-1:0]];
      end
      rd_valid_o = ~empty_s;
      level_o    = level_s;
   end

   // Pointer registers.
   always_ff @(posedge mclk or negedge mclr) begin
      if (!mclr) begin
         wr_q <= {(AW+1){1'b0}};
         rd_q <= {(AW+1){1'b0}};
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge mclk) begin
      if (push_s) begin
         mem_q[wr_q[AW-1:0]] <= data_i;
      end
   end
endmodule

// File: rtl/gps_epoch_scheduler.sv
// Timestamps rising epoch edges per channel and round-robin queues them into a FIFO.
// One capture slot per channel; a second edge before the slot drains sets a sticky overflow.
module gps_epoch_scheduler
   import gps_epoch_scheduler_pkg::*;
(
   input  logic                mclk,
   input  logic                mclr,
   input  logic [NUM_CH-1:0]   epoch_i,
   input  logic [NUM_CH-1:0]   ch_enable_i,
   input  logic [TS_W-1:0]     timestamp_i,
   input  logic                rd_en_i,
   input  logic                clr_ovf_i,
   output logic                rd_valid_o,
   output logic [CH_W-1:0]     rd_ch_o,
   output logic [TS_W-1:0]     rd_ts_o,
   output logic [FIFO_AW:0]    fifo_level_o,
   output logic [NUM_CH-1:0]   pending_o,
   output logic [NUM_CH-1:0]   ovf_o
);
   logic [NUM_CH-1:0] epoch_q;
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] ovf_q, ovf_d;
   logic [TS_W-1:0]   ts_q [NUM_CH];
   logic [TS_W-1:0]   ts_d [NUM_CH];
   logic [CH_W-1:0]   rr_q, rr_d;

   logic [NUM_CH-1:0] rise_s, req_s;
   logic [CH_W-1:0]   idx_s, grant_ch_s;
   logic              grant_vld_s, full_s, gnt_s;
   entry_t            push_entry_s, head_s;

   // A disabled channel cannot win the grant it is about to lose its slot for.
   assign rise_s = epoch_i & ~epoch_q & ch_enable_i;
   assign req_s  = pending_q & ch_enable_i;

   // Round-robin search from rr_q upward, wrapping through the channel index width.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_ch_s  = {CH_W{1'b0}};
      idx_s       = {CH_W{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
         idx_s = rr_q + k[CH_W-1:0];
         if (!grant_vld_s && req_s[idx_s] && !full_s) begin
            grant_vld_s = 1'b1;
            grant_ch_s  = idx_s;
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
      if (grant_vld_s) begin
         rr_d = grant_ch_s + CH_W'(1);
      end else begin
         rr_d = rr_q;
      end
      push_entry_s.ch = grant_ch_s;
      push_entry_s.ts = ts_q[grant_ch_s];
   end

   // Per-channel capture slot: a granted slot may be refilled by an edge in the same cycle.
   always_comb begin
      pending_d = pending_q;
      ovf_d     = ovf_q;
      ts_d      = ts_q;
      gnt_s     = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         gnt_s = grant_vld_s && (grant_ch_s == i[CH_W-1:0]);
         if (!ch_enable_i[i]) begin
            pending_d[i] = 1'b0;
         end else if (rise_s[i]) begin
            pending_d[i] = 1'b1;
            if (!pending_q[i] || gnt_s) begin
               ts_d[i] = timestamp_i;
            end else begin
               ts_d[i] = ts_q[i];
            end
         end else if (gnt_s) begin
            pending_d[i] = 1'b0;
         end else begin
            pending_d[i] = pending_q[i];
         end
         if (rise_s[i] && pending_q[i] && !gnt_s) begin
            ovf_d[i] = 1'b1;
         end else if (clr_ovf_i) begin
            ovf_d[i] = 1'b0;
         end else begin
            ovf_d[i] = ovf_q[i];
         end
      end
   end

   // Channel state registers.
   always_ff @(posedge mclk or negedge mclr) begin
      if (!mclr) begin
         epoch_q   <= {NUM_CH{1'b0}};
         pending_q <= {NUM_CH{1'b0}};
         ovf_q     <= {NUM_CH{1'b0}};
         rr_q      <= {CH_W{1'b0}};
         for (int i = 0; i < NUM_CH; i++) begin
            ts_q[i] <= {TS_W{1'b0}};
         end
      end else begin
         epoch_q   <= epoch_i;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         rr_q      <= rr_d;
         for (int i = 0; i < NUM_CH; i++) begin
            ts_q[i] <= ts_d[i];
         end
      end
   end

   gps_sync_fifo #(
      .DW (ENTRY_W),
      .AW (FIFO_AW)
   ) u_fifo (
      .mclk       (mclk),
      .mclr       (mclr),
      .push_i     (grant_vld_s),
      .data_i     (push_entry_s),
      .pop_i      (rd_en_i),
      .rd_valid_o (rd_valid_o),
      .data_o     (head_s),
      .level_o    (fifo_level_o),
      .full_o     (full_s)
   );

   assign rd_ch_o   = head_s.ch;
   assign rd_ts_o   = head_s.ts;
   assign pending_o = pending_q;
   assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_gps_epoch_scheduler.sv
// Directed bench for gps_epoch_scheduler: each task drives one scenario and
// compares outputs against hand-derived values one time unit after the clock edge.
module tb_gps_epoch_scheduler;
   logic        mclk;
   logic        mclr;
   logic [7:0]  epoch_i;
   logic [7:0]  ch_enable_i;
   logic [31:0] timestamp_i;
   logic        rd_en_i;
   logic        clr_ovf_i;
   logic        rd_valid_o;
   logic [2:0]  rd_ch_o;
   logic [31:0] rd_ts_o;
   logic [4:0]  fifo_level_o;
   logic [7:0]  pending_o;
   logic [7:0]  ovf_o;

   int n_checks = 0;
   int n_pass   = 0;

   gps_epoch_scheduler dut (
      .mclk         (mclk),
      .mclr         (mclr),
      .epoch_i      (epoch_i),
      .ch_enable_i  (ch_enable_i),
      .timestamp_i  (timestamp_i),
      .rd_en_i      (rd_en_i),
      .clr_ovf_i    (clr_ovf_i),
      .rd_valid_o   (rd_valid_o),
      .rd_ch_o      (rd_ch_o),
      .rd_ts_o      (rd_ts_o),
      .fifo_level_o (fifo_level_o),
      .pending_o    (pending_o),
      .ovf_o        (ovf_o)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic do_reset();
      epoch_i     = 8'h00;
      ch_enable_i = 8'hFF;
      timestamp_i = 32'h0;
      rd_en_i     = 1'b0;
      clr_ovf_i   = 1'b0;
      mclr        = 1'b0;
      step();
      step();
      mclr = 1'b1;
   endtask

   // Two rounds of all-channel edges; from reset this queues ch0..7 @base then ch0..7 @base+1.
   task automatic fill16(input logic [31:0] base);
      for (int r = 0; r < 2; r++) begin
         epoch_i     = 8'hFF;
         timestamp_i = base + 32'(r);
         step();
         epoch_i = 8'h00;
         repeat (8) step();
      end
   endtask

   task automatic pop_one();
      rd_en_i = 1'b1;
      step();
      rd_en_i = 1'b0;
   endtask

   task automatic test_reset();
      mclr = 1'b0;
      #2;
      n_checks++;
      if ({rd_valid_o, rd_ch_o, rd_ts_o, fifo_level_o, pending_o, ovf_o} !== 57'h0)
         $display("FAIL reset_outputs: got v=%0b ch=%0d ts=%h lvl=%0d pend=%h ovf=%h, want all 0",
                  rd_valid_o, rd_ch_o, rd_ts_o, fifo_level_o, pending_o, ovf_o);
      else n_pass++;
      do_reset();
      n_checks++;
      if ({rd_valid_o, fifo_level_o, pending_o} !== 14'h0)
         $display("FAIL reset_release: got v=%0b lvl=%0d pend=%h, want 0", rd_valid_o, fifo_level_o, pending_o);
      else n_pass++;
   endtask

   task automatic test_single_epoch();
      do_reset();
      epoch_i     = 8'h08;
      timestamp_i = 32'h100;
      step();
      timestamp_i = 32'h101;
      n_checks++;
      if ({rd_valid_o, pending_o} !== {1'b0, 8'h08})
         $display("FAIL single_latency1: got v=%0b pend=%h, want v=0 pend=08", rd_valid_o, pending_o);
      else n_pass++;
      step();
      n_checks++;
      if ({rd_valid_o, rd_ch_o, rd_ts_o, fifo_level_o, pending_o} !== {1'b1, 3'd3, 32'h100, 5'd1, 8'h00})
         $display("FAIL single_entry: got v=%0b ch=%0d ts=%h lvl=%0d pend=%h, want v=1 ch=3 ts=100 lvl=1 pend=00",
                  rd_valid_o, rd_ch_o, rd_ts_o, fifo_level_o, pending_o);
      else n_pass++;
      epoch_i = 8'h00;
      pop_one();
      n_checks++;
      if ({rd_valid_o, fifo_level_o} !== {1'b0, 5'd0})
         $display("FAIL single_pop: got v=%0b lvl=%0d, want v=0 lvl=0", rd_valid_o, fifo_level_o);
      else n_pass++;
      pop_one();
      n_checks++;
      if ({rd_valid_o, fifo_level_o} !== {1'b0, 5'd0})
         $display("FAIL pop_empty: got v=%0b lvl=%0d, want v=0 lvl=0", rd_valid_o, fifo_level_o);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [2:0]  exp_ch [4];
      logic [31:0] exp_ts [4];
      exp_ch = '{3'd5, 3'd7, 3'd0, 3'd5};
      exp_ts = '{32'h50, 32'h2A0, 32'h2A0, 32'h2A0};
      do_reset();
      epoch_i     = 8'h20;
      timestamp_i = 32'h50;
      step();
      step();
      epoch_i = 8'h00;
      step();
      epoch_i     = 8'hA1;
      timestamp_i = 32'h2A0;
      step();
      n_checks++;
      if (pending_o !== 8'hA1)
         $display("FAIL rr_capture: got pend=%h, want A1", pending_o);
      else n_pass++;
      epoch_i = 8'h00;
      repeat (3) step();
      n_checks++;
      if (fifo_level_o !== 5'd4)
         $display("FAIL rr_level: got %0d, want 4", fifo_level_o);
      else n_pass++;
      for (int j = 0; j < 4; j++) begin
         n_checks++;
         if ({rd_valid_o, rd_ch_o, rd_ts_o} !== {1'b1, exp_ch[j], exp_ts[j]})
            $display("FAIL rr_order[%0d]: got v=%0b ch=%0d ts=%h, want ch=%0d ts=%h",
                     j, rd_valid_o, rd_ch_o, rd_ts_o, exp_ch[j], exp_ts[j]);
         else n_pass++;
         pop_one();
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      epoch_i     = 8'h03;
      timestamp_i = 32'h700;
      step();
      epoch_i = 8'h00;
      step();
      epoch_i     = 8'h02;
      timestamp_i = 32'h701;
      step();
      n_checks++;
      if ({pending_o, ovf_o, fifo_level_o} !== {8'h02, 8'h00, 5'd2})
         $display("FAIL rise_on_grant: got pend=%h ovf=%h lvl=%0d, want pend=02 ovf=00 lvl=2",
                  pending_o, ovf_o, fifo_level_o);
      else n_pass++;
      epoch_i = 8'h00;
      step();
      n_checks++;
      if ({rd_ch_o, rd_ts_o} !== {3'd0, 32'h700}) $display("FAIL b2b_head0: got ch=%0d ts=%h, want 0/700", rd_ch_o, rd_ts_o);
      else n_pass++;
      pop_one();
      n_checks++;
      if ({rd_ch_o, rd_ts_o} !== {3'd1, 32'h700}) $display("FAIL b2b_head1: got ch=%0d ts=%h, want 1/700", rd_ch_o, rd_ts_o);
      else n_pass++;
      pop_one();
      n_checks++;
      if ({rd_ch_o, rd_ts_o, fifo_level_o} !== {3'd1, 32'h701, 5'd1})
         $display("FAIL b2b_head2: got ch=%0d ts=%h lvl=%0d, want 1/701 lvl=1", rd_ch_o, rd_ts_o, fifo_level_o);
      else n_pass++;
      epoch_i     = 8'h08;
      timestamp_i = 32'h222;
      step();
      epoch_i = 8'h00;
      pop_one();
      n_checks++;
      if ({rd_valid_o, rd_ch_o, rd_ts_o, fifo_level_o} !== {1'b1, 3'd3, 32'h222, 5'd1})
         $display("FAIL push_pop_same: got v=%0b ch=%0d ts=%h lvl=%0d, want 1/3/222 lvl=1",
                  rd_valid_o, rd_ch_o, rd_ts_o, fifo_level_o);
      else n_pass++;
   endtask

   task automatic test_overflow();
      do_reset();
      fill16(32'h30);
      epoch_i     = 8'h04;
      timestamp_i = 32'h300;
      step();
      epoch_i = 8'h00;
      step();
      epoch_i     = 8'h04;
      timestamp_i = 32'h301;
      step();
      n_checks++;
      if ({ovf_o, pending_o, fifo_level_o} !== {8'h04, 8'h04, 5'd16})
         $display("FAIL ovf_set: got ovf=%h pend=%h lvl=%0d, want 04/04/16", ovf_o, pending_o, fifo_level_o);
      else n_pass++;
      epoch_i = 8'h00;
      step();
      epoch_i     = 8'h04;
      clr_ovf_i   = 1'b1;
      timestamp_i = 32'h302;
      step();
      n_checks++;
      if (ovf_o !== 8'h04) $display("FAIL ovf_set_wins: got ovf=%h, want 04", ovf_o);
      else n_pass++;
      epoch_i = 8'h00;
      step();
      clr_ovf_i = 1'b0;
      n_checks++;
      if (ovf_o !== 8'h00) $display("FAIL ovf_clear: got ovf=%h, want 00", ovf_o);
      else n_pass++;
      pop_one();
      step();
      rd_en_i = 1'b1;
      repeat (15) step();
      rd_en_i = 1'b0;
      n_checks++;
      if ({rd_ch_o, rd_ts_o, fifo_level_o} !== {3'd2, 32'h300, 5'd1})
         $display("FAIL ovf_kept_ts: got ch=%0d ts=%h lvl=%0d, want 2/300 lvl=1", rd_ch_o, rd_ts_o, fifo_level_o);
      else n_pass++;
   endtask

   task automatic test_full_pop();
      do_reset();
      fill16(32'h40);
      n_checks++;
      if ({fifo_level_o, rd_ch_o, rd_ts_o} !== {5'd16, 3'd0, 32'h40})
         $display("FAIL fill_head: got lvl=%0d ch=%0d ts=%h, want 16/0/40", fifo_level_o, rd_ch_o, rd_ts_o);
      else n_pass++;
      epoch_i     = 8'h40;
      timestamp_i = 32'h400;
      step();
      epoch_i = 8'h00;
      step();
      n_checks++;
      if ({pending_o, fifo_level_o} !== {8'h40, 5'd16})
         $display("FAIL full_blocks: got pend=%h lvl=%0d, want 40/16", pending_o, fifo_level_o);
      else n_pass++;
      pop_one();
      n_checks++;
      if ({pending_o, fifo_level_o} !== {8'h40, 5'd15})
         $display("FAIL full_pop_same: got pend=%h lvl=%0d, want 40/15", pending_o, fifo_level_o);
      else n_pass++;
      step();
      n_checks++;
      if ({pending_o, fifo_level_o} !== {8'h00, 5'd16})
         $display("FAIL full_refill: got pend=%h lvl=%0d, want 00/16", pending_o, fifo_level_o);
      else n_pass++;
      rd_en_i = 1'b1;
      repeat (15) step();
      rd_en_i = 1'b0;
      n_checks++;
      if ({rd_ch_o, rd_ts_o, fifo_level_o} !== {3'd6, 32'h400, 5'd1})
         $display("FAIL full_last: got ch=%0d ts=%h lvl=%0d, want 6/400 lvl=1", rd_ch_o, rd_ts_o, fifo_level_o);
      else n_pass++;
   endtask

   task automatic test_disable();
      do_reset();
      fill16(32'h50);
      epoch_i     = 8'h10;
      timestamp_i = 32'h500;
      step();
      n_checks++;
      if (pending_o !== 8'h10) $display("FAIL dis_pending: got %h, want 10", pending_o);
      else n_pass++;
      ch_enable_i = 8'hEF;
      step();
      n_checks++;
      if (pending_o !== 8'h00) $display("FAIL dis_clear: got %h, want 00", pending_o);
      else n_pass++;
      epoch_i = 8'h00;
      step();
      epoch_i = 8'h10;
      step();
      n_checks++;
      if ({pending_o, ovf_o} !== 16'h0000)
         $display("FAIL dis_ignore: got pend=%h ovf=%h, want 00/00", pending_o, ovf_o);
      else n_pass++;
      ch_enable_i = 8'hFF;
      step();
      epoch_i = 8'h00;
      rd_en_i = 1'b1;
      repeat (16) step();
      rd_en_i = 1'b0;
      step();
      n_checks++;
      if ({rd_valid_o, fifo_level_o, pending_o} !== 14'h0)
         $display("FAIL dis_no_entry: got v=%0b lvl=%0d pend=%h, want 0/0/00", rd_valid_o, fifo_level_o, pending_o);
      else n_pass++;
   endtask

   task automatic test_reset_midstream();
      do_reset();
      fill16(32'h60);
      rd_en_i = 1'b1;
      repeat (7) step();
      rd_en_i = 1'b0;
      n_checks++;
      if ({fifo_level_o, rd_ch_o, rd_ts_o} !== {5'd9, 3'd7, 32'h60})
         $display("FAIL mid_level: got lvl=%0d ch=%0d ts=%h, want 9/7/60", fifo_level_o, rd_ch_o, rd_ts_o);
      else n_pass++;
      mclr = 1'b0;
      #2;
      n_checks++;
      if ({rd_valid_o, rd_ch_o, rd_ts_o, fifo_level_o, pending_o, ovf_o} !== 57'h0)
         $display("FAIL mid_reset: got v=%0b ch=%0d ts=%h lvl=%0d pend=%h ovf=%h, want all 0",
                  rd_valid_o, rd_ch_o, rd_ts_o, fifo_level_o, pending_o, ovf_o);
      else n_pass++;
      step();
      mclr = 1'b1;
      step();
      n_checks++;
      if ({rd_valid_o, fifo_level_o} !== 6'h0)
         $display("FAIL mid_after: got v=%0b lvl=%0d, want 0/0", rd_valid_o, fifo_level_o);
      else n_pass++;
   endtask

   initial begin
      epoch_i     = 8'h00;
      ch_enable_i = 8'hFF;
      timestamp_i = 32'h0;
      rd_en_i     = 1'b0;
      clr_ovf_i   = 1'b0;
      mclr        = 1'b1;
      #3;
      test_reset();
      test_single_epoch();
      test_round_robin();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_disable();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
